// File: rtl/store_checker_pkg.sv
// chk_pkg: status and store-class types shared by store_checker and store_classify.
package chk_pkg;
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RUN        = 3'd1,
    ST_PASS       = 3'd2,
    ST_FAIL_DATA  = 3'd3,
    ST_FAIL_ORDER = 3'd4,
    ST_FAIL_UNEXP = 3'd5,
    ST_TIMEOUT    = 3'd6
  } chk_status_t;
  typedef enum logic [2:0] {
    CL_NONE    = 3'd0,
    CL_MS_OK   = 3'd1,
    CL_MS_BAD  = 3'd2,
    CL_FIN_OK  = 3'd3,
    CL_FIN_BAD = 3'd4,
    CL_OTHER   = 3'd5
  } store_class_t;
  function automatic logic is_terminal(input chk_status_t s);
    return s inside {ST_PASS, ST_FAIL_DATA, ST_FAIL_ORDER, ST_FAIL_UNEXP, ST_TIMEOUT};
  endfunction
endpackage

// File: rtl/store_checker_classify.sv
// store_classify: decodes one cpu store into a milestone/final/other class.
module store_classify
  import chk_pkg::*;
#(
  parameter logic [31:0] MILESTONE_ADDR = 32'd80,
  parameter logic [31:0] MILESTONE_DATA = 32'd7,
  parameter logic [31:0] FINAL_ADDR     = 32'd84,
  parameter logic [31:0] FINAL_DATA     = 32'd7
) (
  input  logic         memwrite,
  input  logic [31:0]  dataaddr,
  input  logic [31:0]  writedata,
  output store_class_t cls
);
  always_comb
    cls = !memwrite ? CL_NONE :
          (dataaddr == MILESTONE_ADDR) ? ((writedata == MILESTONE_DATA) ? CL_MS_OK : CL_MS_BAD) :
          (dataaddr == FINAL_ADDR) ? ((writedata == FINAL_DATA) ? CL_FIN_OK : CL_FIN_BAD) :
          CL_OTHER;
endmodule

// File: rtl/store_checker.sv
// store_checker: end-of-test scoreboard for the cpu store stream (milestones, final store, cycle budget).
// Define STORE_CHECKER_UNEXPECTED_FAIL_EN to fail on stores to any other address.
module store_checker
  import chk_pkg::*;
#(
  parameter logic [31:0] MILESTONE_ADDR = 32'd80,
  parameter logic [31:0] MILESTONE_DATA = 32'd7,
  parameter logic [31:0] FINAL_ADDR     = 32'd84,
  parameter logic [31:0] FINAL_DATA     = 32'd7,
  parameter int          MIN_MILESTONES = 1,
  parameter int          MAX_CYCLES     = 90
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataaddr,
  input  logic [31:0] writedata,
  input  logic [31:0] pc,
  output chk_status_t status,
  output logic        done,
  output logic        pass,
  output logic [7:0]  milestone_cnt,
  output logic [31:0] cycle_cnt,
  output logic [31:0] fail_addr,
  output logic [31:0] fail_data,
  output logic [31:0] fail_pc
);
  localparam logic [31:0] MAX_C = 32'(MAX_CYCLES);
  localparam logic [7:0]  MIN_M = 8'(MIN_MILESTONES);
  store_class_t cls;
  chk_status_t status_q, status_d;
  logic done_q, done_d, pass_q, pass_d;
  logic [7:0] milestone_cnt_q, milestone_cnt_d;
  logic [31:0] cycle_cnt_q, cycle_cnt_d, fail_addr_q, fail_addr_d, fail_data_q, fail_data_d, fail_pc_q, fail_pc_d;
`ifndef STORE_CHECKER_UNEXPECTED_FAIL_EN
  logic [31:0] unexpected_cnt_q, unexpected_cnt_d;
`endif
  store_classify #(
    .MILESTONE_ADDR(MILESTONE_ADDR),
    .MILESTONE_DATA(MILESTONE_DATA),
    .FINAL_ADDR(FINAL_ADDR),
    .FINAL_DATA(FINAL_DATA)
  ) u_classify (
    .memwrite(memwrite),
    .dataaddr(dataaddr),
    .writedata(writedata),
    .cls(cls)
  );
  always_comb begin
    status_d        = status_q;
    milestone_cnt_d = milestone_cnt_q;
    cycle_cnt_d     = cycle_cnt_q;
    fail_addr_d     = fail_addr_q;
    fail_data_d     = fail_data_q;
    fail_pc_d       = fail_pc_q;
`ifndef STORE_CHECKER_UNEXPECTED_FAIL_EN
    unexpected_cnt_d = unexpected_cnt_q;
`endif
    if (status_q == ST_IDLE) status_d = ST_RUN;
    else if (status_q == ST_RUN) begin
      cycle_cnt_d = (cycle_cnt_q >= MAX_C) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
      if (cls == CL_MS_OK) milestone_cnt_d = (milestone_cnt_q == 8'hff) ? milestone_cnt_q : milestone_cnt_q + 8'd1;
      else if (cls == CL_MS_BAD || cls == CL_FIN_BAD) status_d = ST_FAIL_DATA;
      else if (cls == CL_FIN_OK) status_d = (milestone_cnt_q < MIN_M) ? ST_FAIL_ORDER : ST_PASS;
      else if (cls == CL_OTHER)
`ifdef STORE_CHECKER_UNEXPECTED_FAIL_EN
        status_d = ST_FAIL_UNEXP;
`else
        unexpected_cnt_d = unexpected_cnt_q + 32'd1;
`endif
      // a store decision on the budget's last edge wins over the timeout
      if (!is_terminal(status_d) && cycle_cnt_q + 32'd1 == MAX_C) status_d = ST_TIMEOUT;
      if (status_d inside {ST_FAIL_DATA, ST_FAIL_ORDER, ST_FAIL_UNEXP}) begin
        fail_addr_d = dataaddr;
        fail_data_d = writedata;
        fail_pc_d   = pc;
      end
    end
    done_d = is_terminal(status_d);
    pass_d = status_d == ST_PASS;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      status_q        <= ST_IDLE;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      milestone_cnt_q <= '0;
      cycle_cnt_q     <= '0;
      fail_addr_q     <= '0;
      fail_data_q     <= '0;
      fail_pc_q       <= '0;
`ifndef STORE_CHECKER_UNEXPECTED_FAIL_EN
      unexpected_cnt_q <= '0;
`endif
    end else begin
      status_q        <= status_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      milestone_cnt_q <= milestone_cnt_d;
      cycle_cnt_q     <= cycle_cnt_d;
      fail_addr_q     <= fail_addr_d;
      fail_data_q     <= fail_data_d;
      fail_pc_q       <= fail_pc_d;
`ifndef STORE_CHECKER_UNEXPECTED_FAIL_EN
      unexpected_cnt_q <= unexpected_cnt_d;
`endif
    end
`ifndef STORE_CHECKER_UNEXPECTED_FAIL_EN
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (!reset && status_q == ST_RUN && is_terminal(status_d))
      $display("store_checker: %0d unexpected stores ignored", unexpected_cnt_d);
`endif
`endif
  assign status        = status_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign milestone_cnt = milestone_cnt_q;
  assign cycle_cnt     = cycle_cnt_q;
  assign fail_addr     = fail_addr_q;
  assign fail_data     = fail_data_q;
  assign fail_pc       = fail_pc_q;
endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker: directed stimulus with a done-triggered scoreboard for store_checker.
module tb_store_checker;
  import chk_pkg::*;
  typedef struct {
    logic [2:0]  st;
    logic        p;
    logic [7:0]  ms;
    logic [31:0] cyc, fa, fd, fpc;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, memwrite = 1'b0;
  logic [31:0] dataaddr = '0, writedata = '0, pc = '0;
  chk_status_t status;
  logic done, pass, done_prev = 1'b0;
  logic [7:0] milestone_cnt;
  logic [31:0] cycle_cnt, fail_addr, fail_data, fail_pc;
  int checks = 0, failures = 0;
  exp_t sb[$];
  store_checker dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataaddr(dataaddr),
    .writedata(writedata), .pc(pc), .status(status), .done(done), .pass(pass),
    .milestone_cnt(milestone_cnt), .cycle_cnt(cycle_cnt), .fail_addr(fail_addr),
    .fail_data(fail_data), .fail_pc(fail_pc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic push(input chk_status_t st, input logic [7:0] ms, input logic [31:0] cyc,
                      input logic [31:0] fa, input logic [31:0] fd, input logic [31:0] fpc);
    exp_t e;
    e.st = st; e.p = (st == ST_PASS); e.ms = ms; e.cyc = cyc; e.fa = fa; e.fd = fd; e.fpc = fpc;
    sb.push_back(e);
  endtask
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: status=%0d with no expected result", status);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("status", 32'(status), 32'(e.st));
        chk("pass", 32'(pass), 32'(e.p));
        chk("milestone_cnt", 32'(milestone_cnt), 32'(e.ms));
        chk("cycle_cnt", cycle_cnt, e.cyc);
        chk("fail_addr", fail_addr, e.fa);
        chk("fail_data", fail_data, e.fd);
        chk("fail_pc", fail_pc, e.fpc);
      end
    end
    done_prev <= done;
  end
  task automatic do_reset();
    @(negedge clk);
    memwrite = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic run_until(input int n);
    int i;
    for (i = 0; i < 300 && !(status == ST_RUN && cycle_cnt == 32'(n)); i++) @(negedge clk);
    if (i == 300) begin
      failures++;
      $display("FAIL run_until: never reached RUN cycle %0d (status=%0d cycle=%0d)", n, status, cycle_cnt);
    end
  endtask
  task automatic pulse(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p, input int len);
    memwrite = 1'b1; dataaddr = a; writedata = d; pc = p;
    repeat (len) @(negedge clk);
    memwrite = 1'b0;
  endtask
  task automatic store_at(input int n, input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    run_until(n);
    pulse(a, d, p, 1);
  endtask
  task automatic wait_sb();
    int i;
    for (i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL wait_done: done never rose, status=%0d cycle=%0d", status, cycle_cnt);
      sb.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    #2;
    chk("rst_status", 32'(status), 32'(ST_IDLE));
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_fail_pc", fail_pc, 32'd0);
    // basic pass
    do_reset();
    push(ST_PASS, 8'd1, 32'd41, 32'd0, 32'd0, 32'd0);
    store_at(20, 32'd80, 32'd7, 32'h100);
    store_at(40, 32'd84, 32'd7, 32'h200);
    wait_sb();
    chk("pass_done", 32'(done), 32'd1);
    // bad milestone data, later final store must be ignored
    do_reset();
    push(ST_FAIL_DATA, 8'd0, 32'd11, 32'd80, 32'd5, 32'h1234);
    store_at(10, 32'd80, 32'd5, 32'h1234);
    wait_sb();
    pulse(32'd84, 32'd7, 32'h999, 2);
    @(negedge clk);
    chk("sticky_status", 32'(status), 32'(ST_FAIL_DATA));
    chk("sticky_cycle", cycle_cnt, 32'd11);
    chk("sticky_fail_pc", fail_pc, 32'h1234);
    // final before any milestone
    do_reset();
    push(ST_FAIL_ORDER, 8'd0, 32'd6, 32'd84, 32'd7, 32'h44);
    store_at(5, 32'd84, 32'd7, 32'h44);
    wait_sb();
    // bad final data
    do_reset();
    push(ST_FAIL_DATA, 8'd0, 32'd4, 32'd84, 32'd9, 32'h55);
    store_at(3, 32'd84, 32'd9, 32'h55);
    wait_sb();
    // timeout
    do_reset();
    push(ST_TIMEOUT, 8'd0, 32'd90, 32'd0, 32'd0, 32'd0);
    wait_sb();
    // final store on the timeout edge wins
    do_reset();
    push(ST_PASS, 8'd1, 32'd90, 32'd0, 32'd0, 32'd0);
    store_at(10, 32'd80, 32'd7, 32'h10);
    store_at(89, 32'd84, 32'd7, 32'h20);
    wait_sb();
    // held memwrite counts one milestone per edge
    do_reset();
    push(ST_PASS, 8'd3, 32'd21, 32'd0, 32'd0, 32'd0);
    run_until(5);
    pulse(32'd80, 32'd7, 32'h30, 3);
    store_at(20, 32'd84, 32'd7, 32'h40);
    wait_sb();
    // store to an unrelated address
    do_reset();
`ifdef STORE_CHECKER_UNEXPECTED_FAIL_EN
    push(ST_FAIL_UNEXP, 8'd0, 32'd16, 32'd100, 32'd1, 32'h77);
    store_at(15, 32'd100, 32'd1, 32'h77);
    wait_sb();
`else
    store_at(15, 32'd100, 32'd1, 32'h77);
    chk("unexp_status", 32'(status), 32'(ST_RUN));
    chk("unexp_done", 32'(done), 32'd0);
    push(ST_PASS, 8'd1, 32'd32, 32'd0, 32'd0, 32'd0);
    store_at(30, 32'd80, 32'd7, 32'h78);
    store_at(31, 32'd84, 32'd7, 32'h79);
    wait_sb();
`endif
    // async reset mid-run, then IDLE ignores a store
    do_reset();
    store_at(10, 32'd80, 32'd7, 32'h50);
    run_until(30);
    chk("pre_rst_ms", 32'(milestone_cnt), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_status", 32'(status), 32'(ST_IDLE));
    chk("async_ms", 32'(milestone_cnt), 32'd0);
    chk("async_cycle", cycle_cnt, 32'd0);
    chk("async_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    memwrite = 1'b1; dataaddr = 32'd84; writedata = 32'd7;
    @(negedge clk);
    memwrite = 1'b0;
    chk("idle_to_run", 32'(status), 32'(ST_RUN));
    chk("restart_cycle", cycle_cnt, 32'd0);
    @(negedge clk);
    chk("restart_cycle1", cycle_cnt, 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
